// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// State encoding, SPI mode encoding, default sizes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int WORD_DEF   = 8;
  localparam int NUM_SS_DEF = 4;

  function automatic logic [1:0] spi_mode(
    input logic cpol,
    input logic cpha
  );
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: counts H=i_div+1 cycles per tick while i_run,
// toggles SCLK on ticks while i_en, reports edge strobes and count.
module spi_clk_gen #(
  parameter int DIV_W = 8,
  parameter int EW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_cpol,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_sclk,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic [EW-1:0]    o_edge_cnt
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic [EW-1:0]    r_edges;
  logic             w_edge;

  assign o_tick       = i_run && (r_cnt == i_div);
  assign w_edge       = o_tick && i_en;
  // r_edges counts completed edges, so an even count means
  // the edge about to happen is a leading one.
  assign o_lead_edge  = w_edge && !r_edges[0];
  assign o_trail_edge = w_edge && r_edges[0];
  assign o_edge_cnt   = r_edges;
  assign o_sclk       = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_edges <= '0;
    end else begin
      if (!i_run || o_tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + DIV_W'(1);
      if (i_load)      r_sclk <= i_cpol;
      else if (w_edge) r_sclk <= ~r_sclk;
      if (!i_en)       r_edges <= '0;
      else if (w_edge) r_edges <= r_edges + EW'(1);
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// Parametrised full-duplex SPI master, one word per start pulse.
// Ports: start/tx_data/ss_sel/cpol/cpha/clk_div in; busy/done/rx_data out; SCLK/MOSI/MISO/SS_N pins.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int NUM_SS = NUM_SS_DEF,
  parameter int SS_W   = 2,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD-1:0]   tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [WORD-1:0]   rx_data,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_N
);

  localparam int EW = $clog2(2*WORD+1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD-1:0]     r_tx_sh;
  logic [WORD-1:0]     r_rx_sh;
  logic [WORD-1:0]     r_rx_data;
  logic [SS_W-1:0]     r_sel;
  logic [SS_W-1:0]     w_sel_nxt;
  logic                r_cpha;
  logic [DIV_W-1:0]    r_div;
  logic                r_mosi;
  logic [NUM_SS-1:0]   r_ss_n;
  logic [NUM_SS-1:0]   w_ss_dec;
  logic                w_accept;
  logic                w_run;
  logic                w_xfer;
  logic                w_tick;
  logic                w_lead;
  logic                w_trail;
  logic                w_last;
  logic                w_sample;
  logic                w_drive;
  logic                w_sclk;
  logic [EW-1:0]       w_edge_cnt;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_run    = r_state inside {ST_SETUP, ST_XFER, ST_HOLD};
  assign w_xfer   = (r_state == ST_XFER);
  assign w_last   = (w_edge_cnt == EW'(2*WORD-1));
  assign w_sample = r_cpha ? w_trail : w_lead;
  // cpha=0 already put the MSB out at accept, so the final
  // trailing edge has nothing left to shift.
  assign w_drive  = r_cpha ? w_lead : (w_trail && !w_last);
  assign w_sel_nxt = w_accept ? ss_sel : r_sel;

  spi_clk_gen #(.DIV_W(DIV_W), .EW(EW)) u_clk_gen (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_run        (w_run),
    .i_en         (w_xfer),
    .i_load       (w_accept),
    .i_cpol       (cpol),
    .i_div        (r_div),
    .o_tick       (w_tick),
    .o_sclk       (w_sclk),
    .o_lead_edge  (w_lead),
    .o_trail_edge (w_trail),
    .o_edge_cnt   (w_edge_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick) w_state_nxt = ST_XFER;
      ST_XFER:  if (w_tick && w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Out-of-range selects match no line: transfer runs unselected.
  always_comb begin
    w_ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (w_sel_nxt == SS_W'(i)) w_ss_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_sel     <= '0;
      r_cpha    <= 1'b0;
      r_div     <= '0;
      r_mosi    <= 1'b0;
      r_ss_n    <= '1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt inside {ST_SETUP, ST_XFER, ST_HOLD})
        r_ss_n <= w_ss_dec;
      else
        r_ss_n <= '1;
      if (w_accept) begin
        r_sel   <= ss_sel;
        r_cpha  <= cpha;
        r_div   <= clk_div;
        r_rx_sh <= '0;
        r_tx_sh <= cpha ? tx_data : (tx_data << 1);
        r_mosi  <= cpha ? 1'b0 : tx_data[WORD-1];
      end else begin
        if (w_drive) begin
          r_mosi  <= r_tx_sh[WORD-1];
          r_tx_sh <= r_tx_sh << 1;
        end
        if (w_sample) r_rx_sh <= {r_rx_sh[WORD-2:0], MISO};
        if (r_state == ST_HOLD && w_tick) r_rx_data <= r_rx_sh;
        if (r_state == ST_DONE) r_mosi <= 1'b0;
      end
    end
  end

  assign busy    = w_run;
  assign done    = (r_state == ST_DONE);
  assign rx_data = r_rx_data;
  assign SCLK    = w_sclk;
  assign MOSI    = r_mosi;
  assign SS_N    = r_ss_n;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: 8-bit/4-slave instance with a slave
// model, and a 16-bit/2-slave instance with MISO looped to MOSI.
module tb_spi_master_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0;
  logic [7:0] tx0 = '0, div0 = '0;
  logic [1:0] sel0 = '0;
  logic       busy0, done0, sclk0, mosi0;
  logic       miso0 = 1'b0;
  logic [7:0] rx0;
  logic [3:0] ss0;

  logic        start1 = 1'b0, cpol1 = 1'b0, cpha1 = 1'b0;
  logic [15:0] tx1 = '0;
  logic [7:0]  div1 = '0;
  logic [1:0]  sel1 = '0;
  logic        busy1, done1, sclk1, mosi1, miso1;
  logic [15:0] rx1;
  logic [1:0]  ss1;
  assign miso1 = mosi1;

  spi_master_core #(.WORD(8), .NUM_SS(4), .SS_W(2), .DIV_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .tx_data(tx0),
    .ss_sel(sel0), .cpol(cpol0), .cpha(cpha0), .clk_div(div0),
    .busy(busy0), .done(done0), .rx_data(rx0), .SCLK(sclk0),
    .MOSI(mosi0), .MISO(miso0), .SS_N(ss0)
  );

  spi_master_core #(.WORD(16), .NUM_SS(2), .SS_W(2), .DIV_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1),
    .ss_sel(sel1), .cpol(cpol1), .cpha(cpha1), .clk_div(div1),
    .busy(busy1), .done(done1), .rx_data(rx1), .SCLK(sclk1),
    .MOSI(mosi1), .MISO(miso1), .SS_N(ss1)
  );

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] resp;
    logic [1:0] sel;
    int         cyc;
  } vec_t;

  int total = 0;
  int bad = 0;
  int dn0 = 0;
  int dn1 = 0;
  logic [7:0]  q0[$];
  logic [15:0] q1[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboards: every done pops the value queued at start.
  always @(negedge clk) begin
    if (done0) begin
      dn0++;
      chk("done0 expected", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) chk("rx0", 32'(rx0), 32'(q0.pop_front()));
    end
    if (done1) begin
      dn1++;
      chk("done1 expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) chk("rx1", 32'(rx1), 32'(q1.pop_front()));
    end
  end

  // Runs one u0 transfer and plays the slave at each negedge.
  task automatic xfer0(input vec_t v, input int hold, input int pulse2,
                       input int abort_edge, output int dcyc,
                       output logic [7:0] srx);
    logic [7:0] sh;
    logic       prev;
    int         edges;
    sh = v.resp;
    srx = '0;
    edges = 0;
    dcyc = -1;
    tx0 = v.tx; sel0 = v.sel; cpol0 = v.cpol;
    cpha0 = v.cpha; div0 = v.div;
    miso0 = v.cpha ? 1'b0 : v.resp[7];
    prev = sclk0;
    if (abort_edge == 0) q0.push_back(v.resp);
    start0 = 1'b1;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clk);
      if (k == hold) start0 = 1'b0;
      if (k == 1) begin
        tx0 = ~v.tx;
        chk("busy0 cyc1", 32'(busy0), 1);
        chk("sclk0 setup", 32'(sclk0), 32'(v.cpol));
        chk("ss0 setup", 32'(ss0), 32'(4'hF & ~(4'd1 << v.sel)));
      end
      if (pulse2 > 0 && k == pulse2) start0 = 1'b1;
      if (pulse2 > 0 && k == pulse2 + 1) start0 = 1'b0;
      if (sclk0 !== prev) begin
        prev = sclk0;
        if (sclk0 !== v.cpol) begin
          edges++;
          if (!v.cpha) srx = {srx[6:0], mosi0};
          else begin miso0 = sh[7]; sh = sh << 1; end
        end else if (edges % 2 == 1) begin
          edges++;
          if (v.cpha) srx = {srx[6:0], mosi0};
          else begin sh = sh << 1; miso0 = sh[7]; end
        end
      end
      if (abort_edge > 0 && edges == abort_edge) return;
      if (done0) begin
        dcyc = k;
        chk("busy0 at done", 32'(busy0), 0);
        chk("ss0 at done", 32'(ss0), 32'hF);
        chk("sclk0 at done", 32'(sclk0), 32'(v.cpol));
        break;
      end
    end
    start0 = 1'b0;
    if (dcyc < 0) chk("done0 timeout", 0, 1);
  endtask

  task automatic xfer1(input logic [15:0] tx, input logic [1:0] sel,
                       input logic cpol, input logic cpha,
                       input logic [7:0] div, input int cyc,
                       output logic ss_low);
    int dcyc;
    dcyc = -1;
    ss_low = 1'b0;
    tx1 = tx; sel1 = sel; cpol1 = cpol; cpha1 = cpha; div1 = div;
    q1.push_back(tx);
    start1 = 1'b1;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (done1) begin
        dcyc = k;
        chk("ss1 at done", 32'(ss1), 32'h3);
        break;
      end
      if (ss1 !== 2'b11) ss_low = 1'b1;
    end
    if (dcyc < 0) chk("done1 timeout", 0, 1);
    chk("done1 cycle", 32'(dcyc), 32'(cyc));
  endtask

  vec_t        tbl[6];
  vec_t        v;
  int          dcyc;
  int          d_before;
  logic [7:0]  srx;
  logic        ss_low;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'd0,   8'hA5, 8'h3C, 2'd1, 19};
    tbl[1] = '{1'b0, 1'b1, 8'd3,   8'h81, 8'h7E, 2'd0, 73};
    tbl[2] = '{1'b1, 1'b0, 8'd3,   8'h81, 8'h7E, 2'd2, 73};
    tbl[3] = '{1'b1, 1'b1, 8'd3,   8'h81, 8'h7E, 2'd3, 73};
    tbl[4] = '{1'b0, 1'b0, 8'd255, 8'h3C, 8'hA5, 2'd0, 4609};
    tbl[5] = '{1'b1, 1'b1, 8'd0,   8'hC6, 8'h19, 2'd1, 19};

    #12;
    chk("rst busy", 32'(busy0), 0);
    chk("rst done", 32'(done0), 0);
    chk("rst rx", 32'(rx0), 0);
    chk("rst sclk", 32'(sclk0), 0);
    chk("rst mosi", 32'(mosi0), 0);
    chk("rst ss", 32'(ss0), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      xfer0(tbl[i], 1, 0, 0, dcyc, srx);
      chk($sformatf("v%0d done cyc", i), 32'(dcyc), 32'(tbl[i].cyc));
      chk($sformatf("v%0d slave rx", i), 32'(srx), 32'(tbl[i].tx));
      @(negedge clk);
      chk($sformatf("v%0d idle mosi", i), 32'(mosi0), 0);
      chk($sformatf("v%0d idle sclk", i), 32'(sclk0), 32'(tbl[i].cpol));
    end

    // Held start plus a second request while busy.
    d_before = dn0;
    v = '{1'b0, 1'b0, 8'd0, 8'h5A, 8'hC3, 2'd2, 19};
    xfer0(v, 3, 6, 0, dcyc, srx);
    chk("held done cyc", 32'(dcyc), 19);
    chk("held slave rx", 32'(srx), 32'h5A);
    repeat (30) @(negedge clk);
    chk("held one done", 32'(dn0 - d_before), 1);
    chk("held no busy", 32'(busy0), 0);
    chk("rx0 holds", 32'(rx0), 32'hC3);

    // Asynchronous reset in the middle of XFER.
    v = '{1'b1, 1'b0, 8'd0, 8'h96, 8'h69, 2'd3, 19};
    xfer0(v, 1, 0, 7, dcyc, srx);
    d_before = dn0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort ss", 32'(ss0), 32'hF);
    chk("abort sclk", 32'(sclk0), 0);
    chk("abort busy", 32'(busy0), 0);
    chk("abort done", 32'(done0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort no done", 32'(dn0 - d_before), 0);
    xfer0(tbl[0], 1, 0, 0, dcyc, srx);
    chk("post-abort cyc", 32'(dcyc), 19);
    chk("post-abort slave", 32'(srx), 32'hA5);
    @(negedge clk);

    // Unselected loopback on the 16-bit, 2-slave instance.
    xfer1(16'h00FF, 2'd3, 1'b0, 1'b0, 8'd0, 35, ss_low);
    chk("nosel ss idle", 32'(ss_low), 0);
    @(negedge clk);

    // Back-to-back 16-bit transfers, H=2.
    xfer1(16'h1234, 2'd0, 1'b0, 1'b0, 8'd1, 69, ss_low);
    chk("b2b first ss", 32'(ss_low), 1);
    @(negedge clk);
    chk("b2b gap ss", 32'(ss1), 32'h3);
    chk("b2b rx hold", 32'(rx1), 32'h1234);
    xfer1(16'hBEEF, 2'd1, 1'b1, 1'b1, 8'd1, 69, ss_low);
    chk("b2b second ss", 32'(ss_low), 1);
    repeat (3) @(negedge clk);
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
Parametrised SPI master, the successor to the fixed 8-bit, single-slave, 16 MHz SPI bench setup. Word width, slave-select count and the SCLK divider are configurable. CPOL/CPHA (all four SPI modes) are selected per transfer. It sits between the MPU bus-side control logic and the off-chip SPI pins, and runs one full-duplex word per start pulse.

Parameters:
- WORD, 8, bits per transfer (2..32), MSB first
- NUM_SS, 4, number of active-low slave-select lines (1..8)
- SS_W, 2, width of ss_sel (≥ clog2(NUM_SS), min 1)
- DIV_W, 8, width of clk_div

Ports:
- clk  in  1  system clock (16 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- tx_data  in  WORD  word to shift out on MOSI
- ss_sel  in  SS_W  slave index to select
- cpol  in  1  SCLK idle level
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
- clk_div  in  DIV_W  half-period H = clk_div+1 clk cycles
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, rx_data valid
- rx_data  out  WORD  last received word
- SCLK  out  1  SPI clock
- MOSI  out  1  serial data out
- MISO  in  1  serial data in
- SS_N  out  NUM_SS  slave selects, active low

Behaviour:
- Reset (async, any state):
  - busy=0, done=0, rx_data=0, SCLK=0, MOSI=0, SS_N=all 1; FSM goes to IDLE.
  - A reset mid-transfer aborts the transfer with no done pulse.
- Start acceptance: start sampled high in IDLE latches tx_data, ss_sel, cpol, cpha and clk_div. These inputs are ignored from then until the transfer returns to IDLE. start while busy=1 is ignored (no queueing).
- FSM: IDLE → SETUP (H cycles) → XFER (2*WORD*H cycles) → HOLD (H cycles) → DONE (1 cycle) → IDLE.
- Timing (start sampled at edge 0):
  - busy=1 from cycle 1 through cycle (2*WORD+2)*H.
  - done=1 and busy=0 at cycle (2*WORD+2)*H+1.
  - rx_data updates in that same DONE cycle and holds until the next DONE.
- SETUP:
  - SS_N[ss_sel]=0; SCLK=cpol.
  - cpha=0: MOSI = tx[WORD-1] from the first SETUP cycle.
- XFER: SCLK toggles every H cycles, 2*WORD edges total; edges are numbered 1..2*WORD, odd = leading.
  - cpha=0: sample MISO on odd edges; shift MOSI to the next bit on even edges except the last.
  - cpha=1: drive MOSI on odd edges (edge 1 drives the MSB); sample on even edges.
  - Sampling uses the registered MISO at the edge cycle. No extra synchroniser; the pins are assumed timed by constraint.
- HOLD: SCLK=cpol, SS_N stays asserted. SS_N returns to all 1 in the DONE cycle.
- ss_sel ≥ NUM_SS: no SS line asserts, but the transfer still runs and completes (loopback/diagnostic use).
- clk_div=0: H=1, SCLK = clk/2. clk_div=max: H=2^DIV_W. The divide counter wraps back to 0 at H-1.
- MOSI holds its last driven bit through HOLD and returns to 0 in IDLE.
- Between transfers in IDLE, SCLK idles at the latched cpol of the last transfer (0 after reset).

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams: IDLE, SETUP, XFER, HOLD, DONE;
  - the mode encoding {cpol, cpha} → SPI_MODE0..3;
  - default WORD/NUM_SS constants.
- One sub-module, spi_clk_gen: the divide counter plus SCLK toggle. It outputs lead_edge/trail_edge strobes and an edge count, and is enabled by the FSM.
- Shift registers and the FSM stay in spi_master_core.

Test Plan:
1. Mode 0, WORD=8, clk_div=0, tx=0xA5, ss_sel=1, slave model returns 0x3C:
   - MOSI bits read 1,0,1,0,0,1,0,1 on rising edges;
   - SS_N=4'b1101 during the transfer;
   - done at cycle 19; rx_data=0x3C.
2. All modes 1–3 with tx=0x81 and clk_div=3 (H=4):
   - SCLK idles at cpol;
   - the slave model for each mode receives 0x81 and returns 0x7E;
   - done at cycle 73 (18*4+1).
3. start held high for 3 cycles, then a second start pulse while busy:
   - exactly one transfer runs;
   - exactly one done pulse;
   - the second request is not executed.
4. rst_n low during XFER edge 7:
   - SS_N=all 1 and SCLK=0 immediately (asynchronous);
   - busy=0, no done pulse;
   - the next start runs a clean transfer.
5. ss_sel=3 with NUM_SS=2, tx=0xFF, MISO tied to MOSI:
   - SS_N stays 2'b11;
   - done asserts; rx_data=0xFF.
6. WORD=16, clk_div=1, tx=0x1234, back-to-back start issued the cycle after done:
   - rx_data correct for both transfers;
   - SS_N deasserts for at least 1 cycle between the transfers.
